cbus_rr_arbiter: RTL

- Shares the single cbus master port (oreq/oresp) between N cbus requesters: icache/ibus converter, dcache/dbus converter, and future uncached or DMA ports.
- Arbitration is round-robin or fixed-priority and is evaluated only between transactions.
- A grant is locked for the whole (burst) transaction, until the last beat.
- Sits between the IBusToCBus/DBusToCBus converters and the top-level oreq/oresp.

---
 rtl/cbus_rr_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/cbus_rr_arbiter.sv
// Shares one cbus master port among NUM_INPUTS requesters, with round-robin or fixed-priority
// arbitration between transactions and a grant held until the last beat.
package cbus_pkg;
   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
      logic [3:0]  len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;
endpackage

// state   | meaning
// ST_IDLE | no owner; arbitrate among valid requests, oreq and iresps are zero
// ST_BUSY | r_owner holds the port until a beat with ready&last
module cbus_rr_arbiter
   import cbus_pkg::*;
#(
   parameter int NUM_INPUTS = 2,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  cbus_req_t                     ireqs  [NUM_INPUTS],
   output cbus_resp_t                    iresps [NUM_INPUTS],
   output cbus_req_t                     oreq,
   input  cbus_resp_t                    oresp,
   output logic                          busy,
   output logic [$clog2(NUM_INPUTS)-1:0] grant_idx
);
   localparam int IW = $clog2(NUM_INPUTS);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [IW-1:0] r_owner;
   logic [IW-1:0] w_owner_nxt;
   logic [IW-1:0] r_last_owner;
   logic [IW-1:0] w_last_nxt;
   logic [IW-1:0] w_win;
   logic          w_found;
   int            w_cand;

   // Round-robin searches upward from the slot after the previous owner.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = 0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         if (FIXED_PRIO) w_cand = k;
         else            w_cand = (int'(r_last_owner) + 1 + k) % NUM_INPUTS;
         if (!w_found && ireqs[w_cand].valid) begin
            w_found = 1'b1;
            w_win   = IW'(w_cand);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last_owner;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = ST_BUSY;
               w_owner_nxt = w_win;
            end
         end
         ST_BUSY: begin
            if (oresp.ready && oresp.last) begin
               w_state_nxt = ST_IDLE;
               w_last_nxt  = r_owner;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_owner      <= '0;
         r_last_owner <= IW'(NUM_INPUTS - 1);
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_last_owner <= w_last_nxt;
      end
   end

   // Pure selection: requester fields are forwarded untouched.
   always_comb begin
      oreq = '0;
      for (int i = 0; i < NUM_INPUTS; i++) iresps[i] = '0;
      if (r_state == ST_BUSY) begin
         oreq            = ireqs[r_owner];
         iresps[r_owner] = oresp;
      end
   end

   assign busy      = (r_state == ST_BUSY);
   assign grant_idx = r_owner;
endmodule
